// File: rtl/wb_decoder_pkg.sv
// Wishbone bundle types, decoder state codes and the address-window helper
// shared by wb_decoder and its sub-modules.
package wb_decoder_pkg;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } WB_M2S;

    typedef struct packed {
        logic        ack;
        logic        err;
        logic [31:0] dat;
    } WB_S2M;

    localparam logic [1:0] ST_DEC_IDLE   = 2'd0;
    localparam logic [1:0] ST_DEC_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DEC_ERR    = 2'd2;
    localparam logic [1:0] ST_DEC_WAIT   = 2'd3;

    function automatic logic addr_hit(input logic [31:0] adr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
        return (adr & mask) == base;
    endfunction

endpackage

// File: rtl/wb_decoder_watchdog.sv
// Bus watchdog: counts enabled cycles since the last clear and flags when the
// count reaches TIMEOUT-1. Reusable by any bridge that needs a reply deadline.
module wb_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        // NOTE: non-blocking updates so every register samples pre-edge values.
        if (!i_rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/wb_decoder.sv
// Single-initiator, four-responder Wishbone address decoder. Selection is
// locked for the whole CYC; unmapped or unanswered strobes get a local ERR.
module wb_decoder
    import wb_decoder_pkg::*;
#(
    parameter logic [31:0] S0_BASE = 32'h0000_0000,
    parameter logic [31:0] S0_MASK = 32'hF000_0000,
    parameter logic [31:0] S1_BASE = 32'h1000_0000,
    parameter logic [31:0] S1_MASK = 32'hF000_0000,
    parameter logic [31:0] S2_BASE = 32'h2000_0000,
    parameter logic [31:0] S2_MASK = 32'hF000_0000,
    parameter logic [31:0] S3_BASE = 32'h3000_0000,
    parameter logic [31:0] S3_MASK = 32'hF000_0000,
    parameter int          TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  WB_M2S       i_m2s_wb,
    output WB_S2M       o_s2m_wb,
    output WB_M2S       o_m2s0_wb,
    output WB_M2S       o_m2s1_wb,
    output WB_M2S       o_m2s2_wb,
    output WB_M2S       o_m2s3_wb,
    input  WB_S2M       i_s2m0_wb,
    input  WB_S2M       i_s2m1_wb,
    input  WB_S2M       i_s2m2_wb,
    input  WB_S2M       i_s2m3_wb,
    output logic        o_bus_err,
    output logic [31:0] o_err_adr
);

    localparam logic [31:0] BASE [4] = '{S0_BASE, S1_BASE, S2_BASE, S3_BASE};
    localparam logic [31:0] MASK [4] = '{S0_MASK, S1_MASK, S2_MASK, S3_MASK};

    logic [1:0]  state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [31:0] err_adr_q, err_adr_d;

    logic        hit_any;
    logic [1:0]  hit_idx;
    WB_S2M       s2m_rsp [4];
    WB_S2M       sel_rsp;
    WB_M2S       m2s_out [4];
    logic        rsp_done;
    logic        in_active;
    logic        wd_expired;

    // Scan downwards so the lowest matching responder wins.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int k = 3; k >= 0; k--) begin
            if (addr_hit(i_m2s_wb.adr, BASE[k], MASK[k])) begin
                hit_any = 1'b1;
                hit_idx = 2'(k);
            end
        end
    end

    assign s2m_rsp   = '{i_s2m0_wb, i_s2m1_wb, i_s2m2_wb, i_s2m3_wb};
    assign sel_rsp   = s2m_rsp[sel_q];
    assign rsp_done  = sel_rsp.ack | sel_rsp.err;
    assign in_active = (state_q == ST_DEC_ACTIVE);

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .clr     (!in_active || rsp_done || !i_m2s_wb.stb),
        .en      (in_active && i_m2s_wb.stb),
        .expired (wd_expired)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        err_adr_d = err_adr_q;
        case (state_q)
            ST_DEC_IDLE: begin
                if (i_m2s_wb.cyc && i_m2s_wb.stb) begin
                    if (hit_any) begin
                        sel_d   = hit_idx;
                        state_d = ST_DEC_ACTIVE;
                    end else begin
                        err_adr_d = i_m2s_wb.adr;
                        state_d   = ST_DEC_ERR;
                    end
                end
            end
            ST_DEC_ACTIVE: begin
                // A reply on the expiry cycle takes precedence over the timeout.
                if (!i_m2s_wb.cyc) begin
                    state_d = ST_DEC_IDLE;
                end else if (wd_expired && i_m2s_wb.stb && !rsp_done) begin
                    err_adr_d = i_m2s_wb.adr;
                    state_d   = ST_DEC_ERR;
                end
            end
            ST_DEC_ERR: state_d = ST_DEC_WAIT;
            default: begin
                if (!i_m2s_wb.cyc) begin
                    state_d = ST_DEC_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= ST_DEC_IDLE;
            sel_q     <= '0;
            err_adr_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            err_adr_q <= err_adr_d;
        end
    end

    // Outputs decode straight from state so an async reset clears them at once.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            m2s_out[k] = '0;
        end
        o_s2m_wb  = '0;
        o_bus_err = 1'b0;
        case (state_q)
            ST_DEC_ACTIVE: begin
                m2s_out[sel_q] = i_m2s_wb;
                o_s2m_wb       = sel_rsp;
            end
            ST_DEC_ERR: begin
                o_s2m_wb.err = 1'b1;
                o_bus_err    = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_m2s0_wb = m2s_out[0];
    assign o_m2s1_wb = m2s_out[1];
    assign o_m2s2_wb = m2s_out[2];
    assign o_m2s3_wb = m2s_out[3];
    assign o_err_adr = err_adr_q;

endmodule

// File: tb/tb_wb_decoder.sv
// Self-checking bench for wb_decoder: directed scenarios plus randomized
// transactions against a window/latency reference model.
module tb_wb_decoder;
    import wb_decoder_pkg::*;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    WB_M2S       m2s_i;
    WB_S2M       s2m_o;
    WB_M2S       m2s_o [4];
    WB_S2M       s2m_i [4];
    logic        bus_err;
    logic [31:0] err_adr;

    int          n_checks = 0;
    int          n_fail = 0;
    int          rsp_lat = 0;
    int          rsp_cnt [4];
    logic [31:0] exp_err_adr = '0;

    always #5 clk = ~clk;

    wb_decoder #(
        .TIMEOUT (T)
    ) dut (
        .i_clk     (clk),
        .i_rstn    (rstn),
        .i_m2s_wb  (m2s_i),
        .o_s2m_wb  (s2m_o),
        .o_m2s0_wb (m2s_o[0]),
        .o_m2s1_wb (m2s_o[1]),
        .o_m2s2_wb (m2s_o[2]),
        .o_m2s3_wb (m2s_o[3]),
        .i_s2m0_wb (s2m_i[0]),
        .i_s2m1_wb (s2m_i[1]),
        .i_s2m2_wb (s2m_i[2]),
        .i_s2m3_wb (s2m_i[3]),
        .o_bus_err (bus_err),
        .o_err_adr (err_adr)
    );

    function automatic logic [31:0] rsp_sig(input int k);
        return 32'hC0DE_0000 + 32'(k) * 32'h0101_0101;
    endfunction

    // Responders acknowledge after rsp_lat cycles of seeing their strobe.
    always @(posedge clk or negedge rstn) begin
        for (int k = 0; k < 4; k++) begin
            if (!rstn) rsp_cnt[k] <= 0;
            else if (m2s_o[k].cyc && m2s_o[k].stb && !s2m_i[k].ack) rsp_cnt[k] <= rsp_cnt[k] + 1;
            else rsp_cnt[k] <= 0;
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            s2m_i[k] = '0;
            if (m2s_o[k].cyc && m2s_o[k].stb && rsp_cnt[k] == rsp_lat) begin
                s2m_i[k].ack = 1'b1;
                s2m_i[k].dat = m2s_o[k].adr ^ rsp_sig(k);
            end
        end
    end

    // Reference decode: each responder owns one 256 MB window at the bottom of the map.
    function automatic int exp_target(input logic [31:0] adr);
        int win;
        win = int'(adr >> 28);
        return (win < 4) ? win : -1;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cyc, input logic stb, input logic [31:0] adr);
        m2s_i.cyc = cyc;
        m2s_i.stb = stb;
        m2s_i.adr = adr;
        m2s_i.we  = 1'($urandom);
        m2s_i.sel = 4'($urandom);
        m2s_i.dat = $urandom;
    endtask

    task automatic check_outputs(input string tag, input int tgt, input WB_S2M exp_s2m, input logic exp_berr);
        WB_M2S exp_m2s;
        for (int k = 0; k < 4; k++) begin
            exp_m2s = (k == tgt) ? m2s_i : '0;
            check($sformatf("%s m2s%0d", tag, k), 128'(m2s_o[k]), 128'(exp_m2s));
        end
        check($sformatf("%s s2m", tag), 128'(s2m_o), 128'(exp_s2m));
        check($sformatf("%s bus_err", tag), 128'(bus_err), 128'(exp_berr));
    endtask

    // One CYC: nstb back-to-back strobes, the second to adr1, later ones random.
    task automatic run_txn(input logic [31:0] adr0, input logic [31:0] adr1, input int nstb, input int lat);
        int          tgt;
        int          done_at;
        bit          errd;
        logic [31:0] adr;
        WB_S2M       exp_s2m;
        rsp_lat = lat;
        tgt     = exp_target(adr0);
        done_at = (lat < T) ? lat : T;
        adr     = adr0;
        errd    = 1'b0;
        next_cycle();
        drive(1'b1, 1'b1, adr);
        @(negedge clk);
        check_outputs("decode", -1, '0, 1'b0);
        if (tgt < 0) begin
            next_cycle();
            @(negedge clk);
            exp_s2m     = '0;
            exp_s2m.err = 1'b1;
            check_outputs("unmapped", -1, exp_s2m, 1'b1);
            exp_err_adr = adr;
        end else begin
            for (int s = 0; s < nstb && !errd; s++) begin
                for (int i = 0; i <= done_at; i++) begin
                    next_cycle();
                    if (s > 0 && i == 0) begin
                        adr = (s == 1) ? adr1 : $urandom;
                        drive(1'b1, 1'b1, adr);
                    end
                    @(negedge clk);
                    exp_s2m = '0;
                    if (i < done_at) begin
                        check_outputs("wait", tgt, exp_s2m, 1'b0);
                    end else if (lat < T) begin
                        exp_s2m.ack = 1'b1;
                        exp_s2m.dat = adr ^ rsp_sig(tgt);
                        check_outputs("ack", tgt, exp_s2m, 1'b0);
                    end else begin
                        exp_s2m.err = 1'b1;
                        check_outputs("timeout", -1, exp_s2m, 1'b1);
                        errd        = 1'b1;
                        exp_err_adr = adr;
                    end
                end
            end
        end
        next_cycle();
        m2s_i = '0;
        @(negedge clk);
        check_outputs("release", -1, '0, 1'b0);
        next_cycle();
        @(negedge clk);
        check_outputs("idle", -1, '0, 1'b0);
        check("err_adr", 128'(err_adr), 128'(exp_err_adr));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL tb_timeout: simulation did not finish, got running expected done");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        logic [31:0] a;
        int          lat;
        m2s_i = '0;
        rstn  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs("reset", -1, '0, 1'b0);
        check("reset err_adr", 128'(err_adr), 128'(0));
        next_cycle();
        rstn = 1'b1;

        run_txn(32'h1000_0040, 32'h0, 1, 2);
        run_txn(32'h5000_0000, 32'h0, 1, 0);
        run_txn(32'h2000_0010, 32'h0, 1, 1000);
        run_txn(32'h3000_0000, 32'h0000_0004, 2, 1);
        run_txn(32'h0000_0020, 32'h0, 1, T - 1);
        run_txn(32'h1234_5678, 32'h0, 1, T);

        // CYC low while STB and address look like a request: nothing happens.
        next_cycle();
        drive(1'b0, 1'b1, 32'h1000_0000);
        @(negedge clk);
        check_outputs("cyc_low_req", -1, '0, 1'b0);
        next_cycle();
        drive(1'b0, 1'b1, 32'h6000_0000);
        @(negedge clk);
        check_outputs("cyc_low_hold", -1, '0, 1'b0);
        next_cycle();
        @(negedge clk);
        check_outputs("cyc_low_unmapped", -1, '0, 1'b0);
        check("cyc_low err_adr", 128'(err_adr), 128'(exp_err_adr));
        next_cycle();
        m2s_i = '0;

        // Reset in the middle of an ACTIVE transfer.
        rsp_lat = 1000;
        next_cycle();
        drive(1'b1, 1'b1, 32'h1000_0080);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_outputs("pre_reset", 1, '0, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        exp_err_adr = '0;
        check_outputs("async_reset", -1, '0, 1'b0);
        check("async_reset err_adr", 128'(err_adr), 128'(exp_err_adr));
        next_cycle();
        m2s_i = '0;
        next_cycle();
        rstn = 1'b1;
        run_txn(32'h0000_0100, 32'h0, 1, 1);

        for (int n = 0; n < 40; n++) begin
            a = {1'b0, 3'($urandom), 28'($urandom)};
            case ($urandom_range(0, 5))
                4:       lat = T - 1;
                5:       lat = T + int'($urandom_range(0, 3));
                default: lat = int'($urandom_range(0, 3));
            endcase
            run_txn(a, $urandom, int'($urandom_range(1, 3)), lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_decoder.md
# wb_decoder

Wishbone single-initiator, four-responder address decoder with bus watchdog. Sits downstream of `wb_arbiter`: takes the arbitrated initiator bundle, selects one of four responder ports by address window, routes the responder's reply back, and answers locally with an error for unmapped addresses or responders that never acknowledge. Selection is locked for the whole `CYC` period.

## Interface
- `S0_BASE`, 32'h0000_0000: responder 0 base address.
- `S0_MASK`, 32'hF000_0000: responder 0 decode mask.
- `S1_BASE`, 32'h1000_0000: responder 1 base address.
- `S1_MASK`, 32'hF000_0000: responder 1 decode mask.
- `S2_BASE`, 32'h2000_0000: responder 2 base address.
- `S2_MASK`, 32'hF000_0000: responder 2 decode mask.
- `S3_BASE`, 32'h3000_0000: responder 3 base address.
- `S3_MASK`, 32'hF000_0000: responder 3 decode mask.
- `TIMEOUT`, 16: cycles a strobe may wait for `ACK`/`ERR` before the local error; range 2..255.
- `i_clk` in 1: single clock, rising edge.
- `i_rstn` in 1: reset, asynchronous, active-low.
- `i_m2s_wb` in `WB_M2S`: initiator request bundle (from arbiter).
- `o_s2m_wb` out `WB_S2M`: reply to initiator.
- `o_m2s0_wb`..`o_m2s3_wb` out `WB_M2S`: request to responder 0..3.
- `i_s2m0_wb`..`i_s2m3_wb` in `WB_S2M`: reply from responder 0..3.
- `o_bus_err` out 1: one-cycle pulse on every locally generated error.
- `o_err_adr` out 32: address of the last locally errored access; holds until the next error.

## Operation
- FSM states: `IDLE`, `ACTIVE`, `ERR_RSP`, `WAIT_END`.
- `IDLE`: all `o_m2s*` and `o_s2m_wb` are zero.
  - On `CYC & STB`, decode `ADR`.
  - Responder k matches when `(ADR & Sk_MASK) == Sk_BASE`.
  - Lowest matching index wins.
  - On a match: register the select and go to `ACTIVE`.
  - On no match: latch `o_err_adr` and go to `ERR_RSP`.
- `ACTIVE`:
  - The selected `o_m2sk_wb` equals `i_m2s_wb` (combinational); the other three are zero.
  - `o_s2m_wb` equals the selected `i_s2mk_wb`.
  - Multiple strobes within one `CYC` go to the locked responder regardless of address.
  - `CYC` low → `IDLE`, same cycle the responder sees `CYC` low.
- Watchdog in `ACTIVE`:
  - Counter clears on responder `ACK` or `ERR`, on `STB` low, and on state entry.
  - Otherwise it increments while `STB` is high.
  - When it reaches `TIMEOUT-1` without a reply: latch `o_err_adr`, force the selected responder's bundle to zero from the next cycle, go to `ERR_RSP`.
- `ERR_RSP`:
  - `o_s2m_wb[ERR]` = 1 for exactly one cycle; all other `o_s2m_wb` bits are 0.
  - `o_bus_err` pulses in the same cycle.
  - Next state: `WAIT_END`.
- `WAIT_END`: all outputs zero; stays until `CYC` low, then `IDLE`.
- Responder replies arriving in `ERR_RSP` or `WAIT_END` are ignored.
- A responder `ERR` in `ACTIVE` is forwarded unchanged. It is not a local error: no `o_bus_err`, no `o_err_adr` update.

## Timing
- Reset (async, immediate):
  - State `IDLE`, counter 0, `o_err_adr` 0.
  - All bundle outputs and `o_bus_err` are 0.
  - A reset mid-transfer drops the responder `CYC` immediately; there is no completion.
- Decode latency: one cycle. An initiator `STB` seen in cycle n appears at the responder in cycle n+1.
- Reply path in `ACTIVE` is combinational, zero cycles.
- Unmapped access: `ERR` reaches the initiator at n+1 (decode cycle n, `ERR_RSP` at n+1).
- Timeout: the responder first sees `STB` at n+1. The watchdog fires after `TIMEOUT` cycles of unanswered `STB`. `ERR` reaches the initiator at n+1+`TIMEOUT`.
- An `ACK` arriving in the same cycle the count hits `TIMEOUT-1` wins: it is forwarded and there is no error.
- `CYC` dropping in the same cycle as a decode request in `IDLE`: the request is ignored and the state stays `IDLE`.
- Back-to-back transactions need at least one `CYC`-low cycle between them. The arbiter already guarantees this.

## Structure
- Additions to `package.vh`:
  - State codes `ST_DEC_IDLE`, `ST_DEC_ACTIVE`, `ST_DEC_ERR`, `ST_DEC_WAIT`.
  - S2M field index `ERR`, alongside the existing `ACK`/`DAT`; add it if absent.
  - M2S field indices `STB` and `ADR`.
- Sub-module `wb_watchdog`:
  - Parameter `TIMEOUT`.
  - Inputs `clr` and `en`.
  - Output `expired`, registered 8-bit counter.
  - Reusable by future bridges.

## Test plan
- Read to 32'h1000_0040, responder 1 `ACK` after 2 cycles → only `o_m2s1_wb` active (from cycle n+1); initiator `ACK`/data at n+3; other responder outputs stay 0.
- Access to 32'h5000_0000 → `o_s2m_wb[ERR]` = 1 at n+1 for one cycle; `o_bus_err` pulse; `o_err_adr` = 32'h5000_0000; no responder sees `CYC`.
- Responder 2 never acknowledges, `TIMEOUT`=16 → `ERR` at n+17; `o_m2s2_wb` zero from n+17; `o_err_adr` = accessed address; `IDLE` after `CYC` drops.
- Two strobes in one `CYC`: first to 32'h3000_0000, second to 32'h0000_0004 → both reach responder 3 (locked selection).
- `ACK` exactly on the watchdog expiry cycle → `ACK` forwarded; no `ERR`; no `o_bus_err`.
- `i_rstn` low mid-`ACTIVE` → all outputs 0 asynchronously; after release, a fresh access to responder 0 completes normally.
